// File: rtl/usb2_ep_ring_pkg.sv
// Shared constants and helpers for the USB 2.0 endpoint packet ring.
package usb2_ep_pkg;

  // Endpoint transfer type, as presented on the mode input.
  typedef enum logic [1:0] {
    EP_MODE_CONTROL   = 2'd0,
    EP_MODE_ISOCH     = 2'd1,
    EP_MODE_BULK      = 2'd2,
    EP_MODE_INTERRUPT = 2'd3
  } ep_mode_e;

  // Data PID to be used for the next packet.
  typedef enum logic [1:0] {
    DATA_TOGGLE_0 = 2'd0,
    DATA_TOGGLE_1 = 2'd1,
    DATA_TOGGLE_2 = 2'd2,
    DATA_TOGGLE_M = 2'd3
  } data_toggle_e;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/usb2_ep_ring_if.sv
// Endpoint ring bus: protocol-side write port, consumer-side read port,
// PID sequencing and status. The master drives requests, the slave is the ring.
interface usb2_ep_ring_if #(
  parameter int ADDR_W   = 11,
  parameter int BUF_BITS = 2,
  parameter int DATA_W   = 8
);
  logic [ADDR_W-1:0]   buf_in_addr;
  logic [DATA_W-1:0]   buf_in_data;
  logic                buf_in_wren;
  logic                buf_in_ready;
  logic                buf_in_commit;
  logic [ADDR_W:0]     buf_in_commit_len;
  logic                buf_in_commit_ack;
  logic [ADDR_W-1:0]   buf_out_addr;
  logic [DATA_W-1:0]   buf_out_q;
  logic [ADDR_W:0]     buf_out_len;
  logic                buf_out_hasdata;
  logic                buf_out_arm;
  logic                buf_out_arm_ack;
  logic                buf_out_clear;
  logic [1:0]          mode;
  logic                data_toggle_act;
  logic [1:0]          data_toggle;
  logic                sof_pulse;
  logic [BUF_BITS:0]   fill_count;
  logic                overflow;

  modport master (
    output buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
    output buf_out_addr, buf_out_arm, buf_out_clear, mode, data_toggle_act, sof_pulse,
    input  buf_in_ready, buf_in_commit_ack, buf_out_q, buf_out_len, buf_out_hasdata,
    input  buf_out_arm_ack, data_toggle, fill_count, overflow
  );

  modport slave (
    input  buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
    input  buf_out_addr, buf_out_arm, buf_out_clear, mode, data_toggle_act, sof_pulse,
    output buf_in_ready, buf_in_commit_ack, buf_out_q, buf_out_len, buf_out_hasdata,
    output buf_out_arm_ack, data_toggle, fill_count, overflow
  );
endinterface

// File: rtl/usb2_ep_ring_ram.sv
// Simple dual-port packet RAM: one write port, one registered read port, one clock.
module usb2_ep_ring_ram #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  // Store write data; the array itself is never cleared.
  // NOTE: no reset on the storage array so it maps onto block RAM; stale
  // contents are harmless because only committed bytes are ever consumed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read: data appears one cycle after the address.
  always_ff @(posedge clk) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/usb2_ep_ring.sv
// N-deep ring of USB 2.0 endpoint packet buffers over one shared RAM.
// Holds the ring pointers, fill count, per-buffer lengths and the PID sequencer.
module usb2_ep_ring
  import usb2_ep_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int BUF_BITS = 2,
  parameter int DATA_W   = 8
) (
  input  logic           phy_clk,
  input  logic           reset,
  usb2_ep_ring_if.slave  bus
);

  localparam int NUM_BUF  = 1 << BUF_BITS;
  localparam int BUF_SIZE = 1 << ADDR_W;
  localparam int RAM_AW   = clog2(NUM_BUF * BUF_SIZE);
  localparam logic [BUF_BITS:0] FULL_CNT = (BUF_BITS+1)'(NUM_BUF);
  localparam logic [ADDR_W:0]   MAX_LEN  = (ADDR_W+1)'(BUF_SIZE);

  logic [BUF_BITS-1:0] wp, rp;
  logic [BUF_BITS:0]   count;
  logic [ADDR_W:0]     len_q [NUM_BUF];
  logic                overflow_q, commit_ack_q, arm_ack_q;
  logic                full, commit_acc, arm_acc, is_iso;
  logic [ADDR_W:0]     commit_len_sat;
  data_toggle_e        tog_q, tog_d;

  assign full           = (count == FULL_CNT);
  assign commit_acc     = bus.buf_in_commit & ~full & ~bus.buf_out_clear;
  assign arm_acc        = bus.buf_out_arm & (count != '0) & ~bus.buf_out_clear;
  assign commit_len_sat = (bus.buf_in_commit_len > MAX_LEN) ? MAX_LEN : bus.buf_in_commit_len;
  assign is_iso         = (bus.mode == EP_MODE_ISOCH);

  // Ring pointers, fill count, sticky overflow and the accept acknowledges.
  // NOTE: every sequential assignment is non-blocking so all registers see
  // pre-edge values, which the same-cycle commit/arm rules depend on.
  always_ff @(posedge phy_clk) begin
    if (reset) begin
      wp           <= '0;
      rp           <= '0;
      count        <= '0;
      overflow_q   <= 1'b0;
      commit_ack_q <= 1'b0;
      arm_ack_q    <= 1'b0;
    end else if (bus.buf_out_clear) begin
      wp           <= '0;
      rp           <= '0;
      count        <= '0;
      overflow_q   <= 1'b0;
      commit_ack_q <= 1'b0;
      arm_ack_q    <= 1'b0;
    end else begin
      if (commit_acc) wp <= wp + BUF_BITS'(1);
      if (arm_acc)    rp <= rp + BUF_BITS'(1);
      count <= count + (BUF_BITS+1)'(commit_acc) - (BUF_BITS+1)'(arm_acc);
      if (bus.buf_in_commit && full) overflow_q <= 1'b1;
      commit_ack_q <= commit_acc;
      arm_ack_q    <= arm_acc;
    end
  end

  // Packet length of each buffer, captured at commit.
  always_ff @(posedge phy_clk) begin
    if (commit_acc) len_q[wp] <= commit_len_sat;
  end

  // PID sequencer state register.
  always_ff @(posedge phy_clk) begin
    if (reset) tog_q <= DATA_TOGGLE_0;
    else       tog_q <= tog_d;
  end

  // PID sequencer next state: DATA0/1 toggle, or ISO high-bandwidth countdown.
  // NOTE: tog_d is defaulted to the current state first, so no path through
  // this block leaves it unassigned and no latch is inferred.
  always_comb begin
    tog_d = tog_q;
    if (bus.buf_out_clear && !is_iso) begin
      tog_d = DATA_TOGGLE_0;
    end else if (is_iso) begin
      if (bus.sof_pulse) begin
        if (int'(count) >= 3)      tog_d = DATA_TOGGLE_2;
        else if (int'(count) == 2) tog_d = DATA_TOGGLE_1;
        else                       tog_d = DATA_TOGGLE_0;
      end else if (bus.data_toggle_act && tog_q != DATA_TOGGLE_0) begin
        tog_d = data_toggle_e'(tog_q - 2'd1);
      end
    end else if (bus.data_toggle_act) begin
      tog_d = (tog_q == DATA_TOGGLE_1) ? DATA_TOGGLE_0 : DATA_TOGGLE_1;
    end
  end

  usb2_ep_ring_ram #(.AW(RAM_AW), .DW(DATA_W)) u_ram (
    .clk     (phy_clk),
    .reset   (reset),
    .wr_en   (bus.buf_in_wren & ~full),
    .wr_addr ({wp, bus.buf_in_addr}),
    .wr_data (bus.buf_in_data),
    .rd_addr ({rp, bus.buf_out_addr}),
    .rd_data (bus.buf_out_q)
  );

  assign bus.buf_in_ready      = ~full;
  assign bus.buf_in_commit_ack = commit_ack_q;
  assign bus.buf_out_len       = len_q[rp];
  assign bus.buf_out_hasdata   = (count != '0);
  assign bus.buf_out_arm_ack   = arm_ack_q;
  assign bus.data_toggle       = tog_q;
  assign bus.fill_count        = count;
  assign bus.overflow          = overflow_q;

endmodule

// File: tb/tb_usb2_ep_ring.sv
// Self-checking bench for usb2_ep_ring: directed scenarios followed by random
// traffic, all compared against a packet-queue reference model.
module tb_usb2_ep_ring;
  localparam int ADDR_W   = 11;
  localparam int BUF_BITS = 2;
  localparam int DATA_W   = 8;
  localparam int NUM_BUF  = 4;
  localparam int BUF_SIZE = 2048;

  logic phy_clk = 1'b0;
  logic reset;
  always #5 phy_clk = ~phy_clk;

  usb2_ep_ring_if #(.ADDR_W(ADDR_W), .BUF_BITS(BUF_BITS), .DATA_W(DATA_W)) bus ();

  usb2_ep_ring #(.ADDR_W(ADDR_W), .BUF_BITS(BUF_BITS), .DATA_W(DATA_W)) dut (
    .phy_clk (phy_clk),
    .reset   (reset),
    .bus     (bus)
  );

  // Reference model: a FIFO of committed packets with one probe byte each.
  typedef struct {
    int len;
    bit has_probe;
    int paddr;
    int pdata;
  } pkt_t;

  pkt_t mq[$];
  bit   m_ovf, m_cack, m_aack, pend_v;
  int   m_tog, pend_addr, pend_data;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_cack = 1'b0;
    m_aack = 1'b0;
    pend_v = 1'b0;
    m_tog  = 0;
  endtask

  task automatic check_outputs();
    check("ready",    64'(bus.buf_in_ready),      64'(mq.size() < NUM_BUF));
    check("hasdata",  64'(bus.buf_out_hasdata),   64'(mq.size() != 0));
    check("fill",     64'(bus.fill_count),        64'(mq.size()));
    check("overflow", 64'(bus.overflow),          64'(m_ovf));
    check("toggle",   64'(bus.data_toggle),       64'(m_tog));
    check("cack",     64'(bus.buf_in_commit_ack), 64'(m_cack));
    check("aack",     64'(bus.buf_out_arm_ack),   64'(m_aack));
    if (mq.size() != 0) check("len", 64'(bus.buf_out_len), 64'(mq[0].len));
  endtask

  // Advance one clock: update the model from the driven inputs, then compare.
  task automatic clk_step();
    int   c;
    bit   full, clr, cacc, aacc;
    pkt_t p;
    c    = mq.size();
    full = (c == NUM_BUF);
    clr  = bus.buf_out_clear;
    cacc = bus.buf_in_commit && !full && !clr;
    aacc = bus.buf_out_arm && (c != 0) && !clr;
    if (clr && bus.mode != 2'd1) m_tog = 0;
    else if (bus.mode == 2'd1) begin
      if (bus.sof_pulse) m_tog = (c >= 3) ? 2 : (c == 2) ? 1 : 0;
      else if (bus.data_toggle_act && m_tog > 0) m_tog--;
    end else if (bus.data_toggle_act) m_tog = (m_tog == 1) ? 0 : 1;
    if (bus.buf_in_wren && !full) begin
      pend_v    = 1'b1;
      pend_addr = int'(bus.buf_in_addr);
      pend_data = int'(bus.buf_in_data);
    end
    if (clr) begin
      mq.delete();
      m_ovf  = 1'b0;
      pend_v = 1'b0;
    end else begin
      if (bus.buf_in_commit && full) m_ovf = 1'b1;
      if (aacc) void'(mq.pop_front());
      if (cacc) begin
        p.len       = (int'(bus.buf_in_commit_len) > BUF_SIZE) ? BUF_SIZE : int'(bus.buf_in_commit_len);
        p.has_probe = pend_v;
        p.paddr     = pend_addr;
        p.pdata     = pend_data;
        mq.push_back(p);
        pend_v = 1'b0;
      end
    end
    m_cack = cacc;
    m_aack = aacc;
    @(posedge phy_clk);
    #1;
    bus.buf_in_wren     = 1'b0;
    bus.buf_in_commit   = 1'b0;
    bus.buf_out_arm     = 1'b0;
    bus.sof_pulse       = 1'b0;
    bus.data_toggle_act = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    reset                 = 1'b1;
    bus.buf_in_addr       = '0;
    bus.buf_in_data       = '0;
    bus.buf_in_wren       = 1'b0;
    bus.buf_in_commit     = 1'b0;
    bus.buf_in_commit_len = '0;
    bus.buf_out_addr      = '0;
    bus.buf_out_arm       = 1'b0;
    bus.buf_out_clear     = 1'b0;
    bus.data_toggle_act   = 1'b0;
    bus.sof_pulse         = 1'b0;
    @(posedge phy_clk);
    #1;
    @(posedge phy_clk);
    #1;
    model_reset();
    check_outputs();
    check("reset_q", 64'(bus.buf_out_q), 64'd0);
    reset = 1'b0;
  endtask

  task automatic write_byte(input int addr, input int data);
    bus.buf_in_wren = 1'b1;
    bus.buf_in_addr = ADDR_W'(addr);
    bus.buf_in_data = DATA_W'(data);
    clk_step();
  endtask

  task automatic commit(input int len);
    bus.buf_in_commit     = 1'b1;
    bus.buf_in_commit_len = (ADDR_W+1)'(len);
    clk_step();
  endtask

  task automatic arm();
    bus.buf_out_arm = 1'b1;
    clk_step();
  endtask

  task automatic clear();
    bus.buf_out_clear = 1'b1;
    clk_step();
    bus.buf_out_clear = 1'b0;
  endtask

  task automatic fill_pkt(input int len, input int nbytes);
    for (int i = 0; i < nbytes; i++) write_byte(i, int'($urandom_range(0, 255)));
    commit(len);
  endtask

  // Read the probe byte of the oldest packet and compare it.
  task automatic read_check();
    int exp_d;
    if (mq.size() != 0 && mq[0].has_probe) begin
      exp_d = mq[0].pdata;
      bus.buf_out_addr = ADDR_W'(mq[0].paddr);
      clk_step();
      check("rdata", 64'(bus.buf_out_q), 64'(exp_d));
    end
  endtask

  initial begin
    bus.mode = 2'd2;
    do_reset();

    // Single packet: write, commit, read back.
    for (int i = 0; i < 64; i++) write_byte(i, i ^ 8'hA5);
    commit(64);
    check("t1_ack",  64'(bus.buf_in_commit_ack), 64'd1);
    check("t1_fill", 64'(bus.fill_count),        64'd1);
    check("t1_len",  64'(bus.buf_out_len),       64'd64);
    bus.buf_out_addr = ADDR_W'(5);
    clk_step();
    check("t1_rd5",  64'(bus.buf_out_q),         64'(5 ^ 8'hA5));

    // Full ring, overflow, arm, clear.
    for (int i = 0; i < 3; i++) fill_pkt(20 + i, 4);
    check("t2_ready_full", 64'(bus.buf_in_ready), 64'd0);
    commit(100);
    check("t2_drop_ack", 64'(bus.buf_in_commit_ack), 64'd0);
    check("t2_ovf",      64'(bus.overflow),          64'd1);
    arm();
    check("t2_ready_arm", 64'(bus.buf_in_ready), 64'd1);
    check("t2_ovf_stay",  64'(bus.overflow),     64'd1);
    read_check();
    clear();
    check("t2_clr_fill", 64'(bus.fill_count), 64'd0);
    check("t2_clr_ovf",  64'(bus.overflow),   64'd0);

    // Same-cycle commit and arm, below full and at full.
    fill_pkt(7, 2);
    fill_pkt(8, 2);
    bus.buf_out_arm = 1'b1;
    commit(33);
    check("t3_cack", 64'(bus.buf_in_commit_ack), 64'd1);
    check("t3_aack", 64'(bus.buf_out_arm_ack),   64'd1);
    check("t3_fill", 64'(bus.fill_count),        64'd2);
    fill_pkt(9, 2);
    fill_pkt(10, 2);
    bus.buf_out_arm = 1'b1;
    commit(34);
    check("t3f_cack", 64'(bus.buf_in_commit_ack), 64'd0);
    check("t3f_aack", 64'(bus.buf_out_arm_ack),   64'd1);
    check("t3f_fill", 64'(bus.fill_count),        64'd3);
    clear();

    // Pointer wrap with distinct lengths.
    fill_pkt(5, 3);
    for (int i = 0; i < 6; i++) begin
      fill_pkt(10 + i, 3);
      arm();
      check("t4_len", 64'(bus.buf_out_len), 64'(10 + i));
      read_check();
    end
    clear();

    // ISO high-bandwidth PID sequencing.
    bus.mode = 2'd1;
    for (int i = 0; i < 3; i++) fill_pkt(50, 1);
    bus.sof_pulse = 1'b1;
    clk_step();
    check("t5_sof3", 64'(bus.data_toggle), 64'd2);
    bus.data_toggle_act = 1'b1; clk_step();
    check("t5_act1", 64'(bus.data_toggle), 64'd1);
    bus.data_toggle_act = 1'b1; clk_step();
    check("t5_act2", 64'(bus.data_toggle), 64'd0);
    bus.data_toggle_act = 1'b1; clk_step();
    check("t5_act3", 64'(bus.data_toggle), 64'd0);
    arm();
    bus.sof_pulse = 1'b1;
    clk_step();
    check("t5_sof2", 64'(bus.data_toggle), 64'd1);
    clear();
    bus.sof_pulse = 1'b1;
    bus.data_toggle_act = 1'b1;
    clk_step();
    check("t5_sof0", 64'(bus.data_toggle), 64'd0);

    // Bulk toggling and length saturation.
    bus.mode = 2'd2;
    do_reset();
    check("t6_rst_tog", 64'(bus.data_toggle), 64'd0);
    for (int i = 0; i < 3; i++) begin
      bus.data_toggle_act = 1'b1;
      clk_step();
      check("t6_tog", 64'(bus.data_toggle), 64'((i + 1) % 2));
    end
    clear();
    check("t6_clr_tog", 64'(bus.data_toggle), 64'd0);
    commit(BUF_SIZE + 5);
    check("t6_sat", 64'(bus.buf_out_len), 64'(BUF_SIZE));
    clear();

    // Random traffic against the model.
    for (int it = 0; it < 600; it++) begin
      if (it % 60 == 0) bus.mode = 2'($urandom_range(0, 3));
      bus.buf_in_wren       = ($urandom_range(0, 1) == 1);
      bus.buf_in_addr       = ADDR_W'($urandom_range(0, 15));
      bus.buf_in_data       = DATA_W'($urandom_range(0, 255));
      bus.buf_in_commit     = ($urandom_range(0, 4) == 0);
      bus.buf_in_commit_len = (ADDR_W+1)'($urandom_range(0, BUF_SIZE + 20));
      bus.buf_out_arm       = ($urandom_range(0, 4) == 0);
      bus.sof_pulse         = ($urandom_range(0, 7) == 0);
      bus.data_toggle_act   = ($urandom_range(0, 3) == 0);
      bus.buf_out_clear     = ($urandom_range(0, 39) == 0);
      clk_step();
      bus.buf_out_clear = 1'b0;
      if (it % 8 == 0) read_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/usb2_ep_ring.md
Name: usb2_ep_ring

Overview:
Parametrised successor to the two-buffer USB 2.0 endpoint: an N-deep ring of packet buffers with one shared simple-dual-port RAM. The protocol side writes packets and commits them; the opposite side reads the oldest packet and arms it free. It runs in a single phy_clk domain, so there are no synchronizers and commit/arm are 1-cycle pulses. Additions over the previous generation:
- configurable depth and packet size;
- fill count and sticky overflow;
- corrected high-bandwidth ISO PID sequencing.

Parameters:
ADDR_W, 11, byte-address width inside one buffer; BUF_SIZE = 2^ADDR_W.
BUF_BITS, 2, log2 of buffer count; NUM_BUF = 2^BUF_BITS (legal 1..4).
DATA_W, 8, RAM data width.

Ports:
phy_clk  in  1  sole clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
buf_in_addr  in  ADDR_W  write byte address within the current write buffer.
buf_in_data  in  DATA_W  write data.
buf_in_wren  in  1  write strobe.
buf_in_ready  out  1  a free buffer exists (count < NUM_BUF).
buf_in_commit  in  1  1-cycle pulse: current write buffer complete.
buf_in_commit_len  in  ADDR_W+1  packet length in bytes, 0..BUF_SIZE.
buf_in_commit_ack  out  1  1-cycle pulse, accepted commit.
buf_out_addr  in  ADDR_W  read byte address within the oldest buffer.
buf_out_q  out  DATA_W  read data, registered.
buf_out_len  out  ADDR_W+1  length of the oldest buffer.
buf_out_hasdata  out  1  count != 0.
buf_out_arm  in  1  1-cycle pulse: oldest buffer consumed.
buf_out_arm_ack  out  1  1-cycle pulse, accepted arm.
buf_out_clear  in  1  level; flush the ring.
mode  in  2  0 control, 1 isoch, 2 bulk, 3 interrupt.
data_toggle_act  in  1  1-cycle pulse: the current PID was used.
data_toggle  out  2  PID for the next packet: 0 DATA0, 1 DATA1, 2 DATA2.
sof_pulse  in  1  1-cycle pulse at each microframe start.
fill_count  out  BUF_BITS+1  committed, unarmed buffers.
overflow  out  1  sticky: a commit arrived while full.

Behaviour:
- State: write pointer wp, read pointer rp (BUF_BITS each, natural wrap), count, len[NUM_BUF], overflow, data_toggle.
- Reset: wp=rp=count=0, overflow=0, data_toggle=0, acks=0, buf_out_q=0. Consequently buf_in_ready=1, hasdata=0, fill_count=0.
- RAM write address = {wp, buf_in_addr}. A write occurs only when buf_in_wren & buf_in_ready; wren while full is ignored.
- RAM read address = {rp, buf_out_addr}. buf_out_q is valid 1 cycle after the address. Reading while empty returns don't-care data.
- buf_out_len = len[rp]; it is combinational and valid only while hasdata=1.
- Commit is accepted iff buf_in_commit & count<NUM_BUF, using the registered count (pre-edge). On accept:
  - len[wp] <= buf_in_commit_len, saturated to BUF_SIZE;
  - wp++; buf_in_commit_ack=1 on the next cycle.
- Commit while full: dropped, no ack, overflow<=1.
- Arm is accepted iff buf_out_arm & count!=0. On accept: rp++; buf_out_arm_ack=1 on the next cycle. Arm while empty: ignored, no ack.
- Same-cycle commit and arm, both accepted: count unchanged, both acks. When full, the commit is still dropped (ready was 0), even if an arm frees a slot that cycle.
- count <= count + commit_acc - arm_acc. Widths ensure no wrap; count never exceeds NUM_BUF.
- buf_out_clear (level, sampled each cycle) has highest priority below reset:
  - wp=rp=count=0, overflow=0;
  - same-cycle commit/arm are discarded with no acks;
  - data_toggle=0 in non-ISO modes.
- data_toggle in non-ISO modes: data_toggle_act flips 0<->1. DATA2 is never produced.
- data_toggle in ISO mode:
  - sof_pulse loads 2 if count>=3, 1 if count==2, else 0.
  - data_toggle_act decrements, saturating at 0.
  - sof_pulse and data_toggle_act in the same cycle: sof wins.
- A mode change takes effect on the next event; data_toggle itself is not reset by a mode change.
- Reset mid-packet: partial RAM contents are abandoned. Reset overrides every other input.

Decomposition:
- Package usb2_ep_pkg:
  - EP_MODE_CONTROL/ISOCH/BULK/INTERRUPT constants;
  - DATA_TOGGLE_0/1/2/M constants;
  - clog2 helper.
- Sub-module usb2_ep_ring_ram: simple dual-port RAM, depth NUM_BUF*BUF_SIZE, one clock, registered read port. The top level holds pointers, counters and the toggle FSM.

Test Plan:
1. Reset, then write 64 bytes at buf_in_addr 0..63 and commit len=64 → ack 1 cycle later; hasdata=1; fill_count=1; buf_out_len=64; buf_out_addr 5 returns the byte written at 5 one cycle later.
2. NUM_BUF=4: 4 commits → buf_in_ready=0; 5th commit → no ack, overflow=1. Arm → ready=1, overflow stays 1. buf_out_clear → fill_count=0, overflow=0.
3. Count=2, assert commit and arm in the same cycle → both acks, fill_count stays 2. Repeat at count=4 → only arm_ack, fill_count=3.
4. Wrap: 6 commit/arm pairs with distinct lengths 10..15 → buf_out_len sequence 10,11,...,15, no data corruption across the rp/wp wrap.
5. ISO, count=3, sof_pulse → data_toggle=2; act → 1; act → 0; act → 0. count=2, sof → 1. count=0, sof+act in the same cycle → 0.
6. Bulk: after reset data_toggle=0; 3 act pulses → 1,0,1. buf_out_clear → 0. commit_len=BUF_SIZE+5 → buf_out_len=BUF_SIZE.
